// File: rtl/mem_access_ctrl_if.sv
// Data-bus interface between the memory access controller and the memory
// system. The controller holds the master side; the memory (or a testbench
// model of it) holds the slave side.
interface mem_access_ctrl_if;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    modport master (
        output dbus_req_o,
        output dbus_we_o,
        output dbus_addr_o,
        output dbus_be_o,
        output dbus_wdata_o,
        input  dbus_gnt_i,
        input  dbus_rvalid_i,
        input  dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o,
        input  dbus_we_o,
        input  dbus_addr_o,
        input  dbus_be_o,
        input  dbus_wdata_o,
        output dbus_gnt_i,
        output dbus_rvalid_i,
        output dbus_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller for the MEM stage. It takes a load or store
// from EX/MEM, runs it on the data bus with a req/gnt then rvalid
// handshake, and returns the extended load result. Misaligned or illegal
// accesses are flagged and never reach the bus. A flush either cancels
// the request before it is granted or discards the outstanding response.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exmem_mtype_i,
    input  logic        exmem_mem_rw_i,
    input  logic [1:0]  exmem_mem_width_i,
    input  logic [31:0] exmem_mem_addr_i,
    input  logic        exmem_mem_rdtype_i,
    input  logic [31:0] exmem_reg_wdata_i,
    input  logic        exmem_ins_flag,
    input  logic        fc_flush_mem_i,
    mem_access_ctrl_if.master dbus,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_req_o,
    output logic        mem_misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        discard_q;
    logic        discard_next;

    logic [31:0] addr_q;
    logic [1:0]  width_q;
    logic        rw_q;
    logic        rdtype_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        misalign;
    logic        start;
    logic        req;
    logic        load_update;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;

    // Alignment check and start decode on the live EX/MEM inputs
    always_comb begin
        misalign = exmem_mtype_i & exmem_ins_flag &
                   ((exmem_mem_width_i == 2'b11) |
                    ((exmem_mem_width_i == 2'b01) & exmem_mem_addr_i[0]) |
                    ((exmem_mem_width_i == 2'b10) & (exmem_mem_addr_i[1:0] != 2'b00)));
        start    = exmem_mtype_i & exmem_ins_flag & ~misalign & ~fc_flush_mem_i;
    end

    // Next-state and discard-flag logic; a flush in the grant cycle counts as after grant
    always_comb begin
        state_next   = state;
        discard_next = discard_q;
        case (state)
            IDLE: begin
                discard_next = 1'b0;
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dbus.dbus_gnt_i) begin
                    if (rw_q) begin
                        state_next = fc_flush_mem_i ? IDLE : DONE;
                    end else begin
                        state_next   = WAIT;
                        discard_next = fc_flush_mem_i;
                    end
                end else if (fc_flush_mem_i) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (dbus.dbus_rvalid_i) begin
                    state_next   = (discard_q | fc_flush_mem_i) ? IDLE : DONE;
                    discard_next = 1'b0;
                end else if (fc_flush_mem_i) begin
                    discard_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                discard_next = 1'b0;
            end
        endcase
    end

    // State and discard flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state     <= state_next;
            discard_q <= discard_next;
        end
    end

    // Capture the access attributes when a new access starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 32'h0;
            width_q  <= 2'b00;
            rw_q     <= 1'b0;
            rdtype_q <= 1'b0;
            wdata_q  <= 32'h0;
        end else if ((state == IDLE) && start) begin
            addr_q   <= exmem_mem_addr_i;
            width_q  <= exmem_mem_width_i;
            rw_q     <= exmem_mem_rw_i;
            rdtype_q <= exmem_mem_rdtype_i;
            wdata_q  <= exmem_reg_wdata_i;
        end
    end

    // Lane selection and sign/zero extension of returned load data
    always_comb begin
        byte_lane = dbus.dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_lane = dbus.dbus_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (width_q)
            2'b00:   load_ext = rdtype_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = rdtype_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = dbus.dbus_rdata_i;
        endcase
        load_update = (state == WAIT) & dbus.dbus_rvalid_i & ~discard_q & ~fc_flush_mem_i;
    end

    // Load result register, only written by a completed, non-discarded load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
        end else if (load_update) begin
            rdata_q <= load_ext;
        end
    end

    // Byte enables and replicated store data from the captured width and offset
    always_comb begin
        case (width_q)
            2'b00: begin
                be          = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be          = 4'b0011 << addr_q[1:0];
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be          = 4'b1111;
                wdata_lanes = wdata_q;
            end
            default: begin
                be          = 4'b0000;
                wdata_lanes = 32'h0;
            end
        endcase
    end

    // Bus drive: request only in REQ, dropped at once by a flush that beats the grant
    always_comb begin
        req               = (state == REQ) & ~(fc_flush_mem_i & ~dbus.dbus_gnt_i);
        dbus.dbus_req_o   = req;
        dbus.dbus_we_o    = req & rw_q;
        dbus.dbus_addr_o  = req ? {addr_q[31:2], 2'b00} : 32'h0;
        dbus.dbus_be_o    = req ? be : 4'b0000;
        dbus.dbus_wdata_o = (req & rw_q) ? wdata_lanes : 32'h0;
    end

    // Status outputs; the combinational IDLE terms are held low during reset
    always_comb begin
        mem_rdata_o     = rdata_q;
        mem_done_o      = (state == DONE);
        mem_stall_req_o = (rst_n & (state == IDLE) & start) | (state == REQ) | (state == WAIT);
        mem_misalign_o  = rst_n & (state == IDLE) & misalign;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl. The bench plays the memory side of
// the data bus and the EX/MEM stage, one task per scenario.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        exmem_mtype_i;
    logic        exmem_mem_rw_i;
    logic [1:0]  exmem_mem_width_i;
    logic [31:0] exmem_mem_addr_i;
    logic        exmem_mem_rdtype_i;
    logic [31:0] exmem_reg_wdata_i;
    logic        exmem_ins_flag;
    logic        fc_flush_mem_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_stall_req_o;
    logic        mem_misalign_o;

    int checks;
    int passes;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .exmem_mtype_i      (exmem_mtype_i),
        .exmem_mem_rw_i     (exmem_mem_rw_i),
        .exmem_mem_width_i  (exmem_mem_width_i),
        .exmem_mem_addr_i   (exmem_mem_addr_i),
        .exmem_mem_rdtype_i (exmem_mem_rdtype_i),
        .exmem_reg_wdata_i  (exmem_reg_wdata_i),
        .exmem_ins_flag     (exmem_ins_flag),
        .fc_flush_mem_i     (fc_flush_mem_i),
        .dbus               (bus.master),
        .mem_rdata_o        (mem_rdata_o),
        .mem_done_o         (mem_done_o),
        .mem_stall_req_o    (mem_stall_req_o),
        .mem_misalign_o     (mem_misalign_o)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout got running want finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_access(input logic rw, input logic [1:0] width, input logic [31:0] addr,
                              input logic rdtype, input logic [31:0] d);
        exmem_mtype_i      = 1'b1;
        exmem_ins_flag     = 1'b1;
        exmem_mem_rw_i     = rw;
        exmem_mem_width_i  = width;
        exmem_mem_addr_i   = addr;
        exmem_mem_rdtype_i = rdtype;
        exmem_reg_wdata_i  = d;
    endtask

    task automatic clear_access();
        exmem_mtype_i      = 1'b0;
        exmem_ins_flag     = 1'b0;
        exmem_mem_rw_i     = 1'b0;
        exmem_mem_width_i  = 2'b00;
        exmem_mem_addr_i   = 32'h0;
        exmem_mem_rdtype_i = 1'b0;
        exmem_reg_wdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        clear_access();
        fc_flush_mem_i    = 1'b0;
        bus.dbus_gnt_i    = 1'b0;
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = 32'h0;
        rst_n = 1'b0;
        #2;
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL rst_req got %0b want 0", bus.dbus_req_o); else passes++;
        checks++; if (bus.dbus_addr_o !== 32'h0) $display("[TB] FAIL rst_addr got %h want 0", bus.dbus_addr_o); else passes++;
        checks++; if (mem_rdata_o !== 32'h0) $display("[TB] FAIL rst_rdata got %h want 0", mem_rdata_o); else passes++;
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL rst_done got %0b want 0", mem_done_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL rst_stall got %0b want 0", mem_stall_req_o); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte();
        cycle();
        set_access(1'b0, 2'b00, 32'h0000_1003, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL lb_start_stall got %0b want 1", mem_stall_req_o); else passes++;
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL lb_start_req got %0b want 0", bus.dbus_req_o); else passes++;
        cycle();
        clear_access();
        bus.dbus_gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.dbus_req_o !== 1'b1) $display("[TB] FAIL lb_req got %0b want 1", bus.dbus_req_o); else passes++;
        checks++; if (bus.dbus_addr_o !== 32'h0000_1000) $display("[TB] FAIL lb_addr got %h want 00001000", bus.dbus_addr_o); else passes++;
        checks++; if (bus.dbus_be_o !== 4'b1000) $display("[TB] FAIL lb_be got %b want 1000", bus.dbus_be_o); else passes++;
        checks++; if (bus.dbus_we_o !== 1'b0) $display("[TB] FAIL lb_we got %0b want 0", bus.dbus_we_o); else passes++;
        cycle();
        bus.dbus_gnt_i    = 1'b0;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'h8011_2233;
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL lb_wait_stall got %0b want 1", mem_stall_req_o); else passes++;
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL lb_wait_req got %0b want 0", bus.dbus_req_o); else passes++;
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL lb_wait_done got %0b want 0", mem_done_o); else passes++;
        cycle();
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = 32'h0;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b1) $display("[TB] FAIL lb_done got %0b want 1", mem_done_o); else passes++;
        checks++; if (mem_rdata_o !== 32'hFFFF_FF80) $display("[TB] FAIL lb_rdata got %h want ffffff80", mem_rdata_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL lb_done_stall got %0b want 0", mem_stall_req_o); else passes++;
        cycle();
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL lb_done_pulse got %0b want 0", mem_done_o); else passes++;
    endtask

    task automatic test_load_half_signed();
        cycle();
        set_access(1'b0, 2'b01, 32'h0000_4000, 1'b0, 32'h0);
        cycle();
        clear_access();
        bus.dbus_gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.dbus_be_o !== 4'b0011) $display("[TB] FAIL lh_be got %b want 0011", bus.dbus_be_o); else passes++;
        cycle();
        bus.dbus_gnt_i    = 1'b0;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'h1234_8001;
        cycle();
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = 32'h0;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b1) $display("[TB] FAIL lh_done got %0b want 1", mem_done_o); else passes++;
        checks++; if (mem_rdata_o !== 32'hFFFF_8001) $display("[TB] FAIL lh_rdata got %h want ffff8001", mem_rdata_o); else passes++;
        cycle();
    endtask

    task automatic test_store_half();
        int latency;
        logic done_seen;
        latency   = 0;
        done_seen = 1'b0;
        cycle();
        set_access(1'b1, 2'b01, 32'h0000_2002, 1'b0, 32'h0000_BEEF);
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL sh_start_stall got %0b want 1", mem_stall_req_o); else passes++;
        for (int i = 1; i <= 10 && !done_seen; i++) begin
            cycle();
            if (i == 1) clear_access();
            bus.dbus_gnt_i = (i == 4);
            @(negedge clk);
            if (i <= 4) begin
                checks++; if (bus.dbus_req_o !== 1'b1) $display("[TB] FAIL sh_req cycle %0d got %0b want 1", i, bus.dbus_req_o); else passes++;
                checks++; if (bus.dbus_be_o !== 4'b1100) $display("[TB] FAIL sh_be cycle %0d got %b want 1100", i, bus.dbus_be_o); else passes++;
                checks++; if (bus.dbus_wdata_o !== 32'hBEEF_BEEF) $display("[TB] FAIL sh_wdata cycle %0d got %h want beefbeef", i, bus.dbus_wdata_o); else passes++;
                checks++; if (bus.dbus_we_o !== 1'b1) $display("[TB] FAIL sh_we cycle %0d got %0b want 1", i, bus.dbus_we_o); else passes++;
            end
            if (mem_done_o === 1'b1) begin
                done_seen = 1'b1;
                latency   = i;
            end
        end
        bus.dbus_gnt_i = 1'b0;
        checks++; if (latency != 5) $display("[TB] FAIL sh_latency got %0d want 5", latency); else passes++;
        checks++; if (mem_rdata_o !== 32'hFFFF_8001) $display("[TB] FAIL sh_rdata_kept got %h want ffff8001", mem_rdata_o); else passes++;
        cycle();
    endtask

    task automatic test_misalign();
        cycle();
        set_access(1'b0, 2'b10, 32'h0000_3001, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (mem_misalign_o !== 1'b1) $display("[TB] FAIL ma_word_flag got %0b want 1", mem_misalign_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL ma_word_stall got %0b want 0", mem_stall_req_o); else passes++;
        cycle();
        @(negedge clk);
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL ma_word_req got %0b want 0", bus.dbus_req_o); else passes++;
        cycle();
        set_access(1'b0, 2'b11, 32'h0000_3000, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (mem_misalign_o !== 1'b1) $display("[TB] FAIL ma_ill_flag got %0b want 1", mem_misalign_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL ma_ill_stall got %0b want 0", mem_stall_req_o); else passes++;
        cycle();
        @(negedge clk);
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL ma_ill_req got %0b want 0", bus.dbus_req_o); else passes++;
        cycle();
        clear_access();
        @(negedge clk);
        checks++; if (mem_misalign_o !== 1'b0) $display("[TB] FAIL ma_clear got %0b want 0", mem_misalign_o); else passes++;
    endtask

    task automatic test_flush_wait();
        cycle();
        set_access(1'b0, 2'b01, 32'h0000_4002, 1'b1, 32'h0);
        cycle();
        clear_access();
        bus.dbus_gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.dbus_addr_o !== 32'h0000_4000) $display("[TB] FAIL fl_addr got %h want 00004000", bus.dbus_addr_o); else passes++;
        checks++; if (bus.dbus_be_o !== 4'b1100) $display("[TB] FAIL fl_be got %b want 1100", bus.dbus_be_o); else passes++;
        cycle();
        bus.dbus_gnt_i = 1'b0;
        fc_flush_mem_i = 1'b1;
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL fl_wait_stall got %0b want 1", mem_stall_req_o); else passes++;
        cycle();
        fc_flush_mem_i    = 1'b0;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL fl_rv_stall got %0b want 1", mem_stall_req_o); else passes++;
        cycle();
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = 32'h0;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL fl_done got %0b want 0", mem_done_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL fl_idle_stall got %0b want 0", mem_stall_req_o); else passes++;
        checks++; if (mem_rdata_o !== 32'hFFFF_8001) $display("[TB] FAIL fl_rdata got %h want ffff8001", mem_rdata_o); else passes++;
        cycle();
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL fl_done_late got %0b want 0", mem_done_o); else passes++;
    endtask

    task automatic test_back_to_back();
        cycle();
        set_access(1'b1, 2'b00, 32'h0000_5001, 1'b0, 32'h0000_00A5);
        cycle();
        bus.dbus_gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.dbus_be_o !== 4'b0010) $display("[TB] FAIL bb1_be got %b want 0010", bus.dbus_be_o); else passes++;
        checks++; if (bus.dbus_wdata_o !== 32'hA5A5_A5A5) $display("[TB] FAIL bb1_wdata got %h want a5a5a5a5", bus.dbus_wdata_o); else passes++;
        cycle();
        bus.dbus_gnt_i = 1'b0;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b1) $display("[TB] FAIL bb1_done got %0b want 1", mem_done_o); else passes++;
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL bb1_done_req got %0b want 0", bus.dbus_req_o); else passes++;
        cycle();
        set_access(1'b1, 2'b10, 32'h0000_6000, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL bb_bubble_req got %0b want 0", bus.dbus_req_o); else passes++;
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL bb_bubble_done got %0b want 0", mem_done_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b1) $display("[TB] FAIL bb_bubble_stall got %0b want 1", mem_stall_req_o); else passes++;
        cycle();
        @(negedge clk);
        checks++; if (bus.dbus_req_o !== 1'b1) $display("[TB] FAIL bb2_req got %0b want 1", bus.dbus_req_o); else passes++;
        checks++; if (bus.dbus_be_o !== 4'b1111) $display("[TB] FAIL bb2_be got %b want 1111", bus.dbus_be_o); else passes++;
        checks++; if (bus.dbus_wdata_o !== 32'hDEAD_BEEF) $display("[TB] FAIL bb2_wdata got %h want deadbeef", bus.dbus_wdata_o); else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dbus_req_o !== 1'b0) $display("[TB] FAIL mr_req got %0b want 0", bus.dbus_req_o); else passes++;
        checks++; if (bus.dbus_we_o !== 1'b0) $display("[TB] FAIL mr_we got %0b want 0", bus.dbus_we_o); else passes++;
        checks++; if (bus.dbus_be_o !== 4'b0000) $display("[TB] FAIL mr_be got %b want 0000", bus.dbus_be_o); else passes++;
        checks++; if (bus.dbus_wdata_o !== 32'h0) $display("[TB] FAIL mr_wdata got %h want 0", bus.dbus_wdata_o); else passes++;
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL mr_stall got %0b want 0", mem_stall_req_o); else passes++;
        checks++; if (mem_rdata_o !== 32'h0) $display("[TB] FAIL mr_rdata got %h want 0", mem_rdata_o); else passes++;
        clear_access();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stale_rvalid();
        cycle();
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (mem_stall_req_o !== 1'b0) $display("[TB] FAIL st_stall got %0b want 0", mem_stall_req_o); else passes++;
        cycle();
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i  = 32'h0;
        @(negedge clk);
        checks++; if (mem_done_o !== 1'b0) $display("[TB] FAIL st_done got %0b want 0", mem_done_o); else passes++;
        checks++; if (mem_rdata_o !== 32'h0) $display("[TB] FAIL st_rdata got %h want 0", mem_rdata_o); else passes++;
    endtask

    // Scenario sequence and summary
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_load_byte();
        test_load_half_signed();
        test_store_half();
        test_misalign();
        test_flush_wait();
        test_back_to_back();
        test_stale_rvalid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- exmem_mtype_i  in  1  1 = memory instruction.
- exmem_mem_rw_i  in  1  0 = load, 1 = store.
- exmem_mem_width_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- exmem_mem_addr_i  in  32  byte address.
- exmem_mem_rdtype_i  in  1  load extension: 0 = sign, 1 = zero.
- exmem_reg_wdata_i  in  32  store data.
- exmem_ins_flag  in  1  valid instruction in EX/MEM.
- fc_flush_mem_i  in  1  abort the current access.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  32  word-aligned address, bits [1:0] = 0.
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  lane-aligned store data.
- dbus_gnt_i  in  1  request accepted.
- dbus_rvalid_i  in  1  read data valid.
- dbus_rdata_i  in  32  read data.
- mem_rdata_o  out  32  extended load result.
- mem_done_o  out  1  access complete pulse.
- mem_stall_req_o  out  1  stall request to fc.
- mem_misalign_o  out  1  misaligned or illegal access flag.

Function
REQ-002 The FSM SHALL have four states, IDLE, REQ, WAIT and DONE, with state DONE lasting exactly 1 cycle.
REQ-003 In IDLE, start = exmem_mtype_i & exmem_ins_flag & ~misalign & ~fc_flush_mem_i; on start the block SHALL capture addr, width, rw, rdtype and wdata, then go to REQ.
REQ-004 misalign = exmem_mtype_i & exmem_ins_flag & (width==11 | (width==01 & addr[0]) | (width==10 & addr[1:0]!=0)).
- In IDLE, mem_misalign_o SHALL equal misalign, combinationally.
- A misaligned access SHALL NOT issue a bus request and SHALL NOT stall.
REQ-005 mem_stall_req_o SHALL be (IDLE & start) | REQ | WAIT, combinationally.
- It SHALL be low in DONE so that EX/MEM advances at the end of DONE.
REQ-006 In REQ, dbus_req_o SHALL be 1 and the bus outputs SHALL be driven from the captured values, held stable until gnt.
- On dbus_gnt_i: a store goes to DONE; a load goes to WAIT.
REQ-007 In WAIT, on dbus_rvalid_i the block SHALL register the extended load result into mem_rdata_o, then go to DONE.
- rvalid is sampled only in WAIT; the bus returns rvalid at least 1 cycle after gnt.
REQ-008 DONE SHALL assert mem_done_o for 1 cycle, then go to IDLE unconditionally.
- A new start is not evaluated in DONE, so back-to-back accesses incur 1 bubble.
REQ-009 dbus_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-010 Byte enables and store data SHALL be formed by width, with s = addr[1:0]:
- byte: be = 4'b0001 << s, wdata = {4{d[7:0]}}.
- half: be = 4'b0011 << s, wdata = {2{d[15:0]}}.
- word: be = 4'b1111, wdata = d.
REQ-011 The load lane SHALL be selected by addr[1:0]:
- byte: dbus_rdata_i[8s+7:8s].
- half: dbus_rdata_i[16*s[1]+15:16*s[1]].
- The lane SHALL be sign- or zero-extended to 32 bits per rdtype.
- A word load SHALL pass the data through unchanged.
REQ-012 mem_rdata_o SHALL hold its last value until the next completed load; stores SHALL NOT modify it.
REQ-013 Latency from start to mem_done_o:
- store: 2 cycles + gnt wait.
- load: 3 cycles + gnt wait + rvalid wait.
REQ-014 fc_flush_mem_i in REQ before gnt SHALL drop dbus_req_o in the same cycle and go to IDLE.
- Flush in the cycle gnt is also high SHALL be treated as flush after gnt.
REQ-015 fc_flush_mem_i after gnt SHALL set a discard flag:
- A store then goes to IDLE without mem_done_o.
- A load stays in WAIT until rvalid, consumes it without updating mem_rdata_o or asserting mem_done_o, then goes to IDLE.
REQ-016 Outside REQ, dbus_req_o SHALL be 0; dbus_we_o, dbus_be_o and dbus_wdata_o SHALL be 0 when dbus_req_o is 0.

Reset
REQ-017 On rst_n low, asynchronously:
- the state SHALL be IDLE and the discard flag 0;
- all captured registers and mem_rdata_o SHALL be 0;
- all outputs SHALL be 0.
REQ-018 Reset asserted mid-access SHALL abandon the access with no done pulse; after reset the block SHALL ignore any stale rvalid.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load byte, addr 0x1003, rdtype 0, gnt immediately, rvalid 1 cycle later with rdata 0x80112233:
  - bus: req with addr 0x1000, be 1000;
  - result: mem_rdata_o = 0xFFFFFF80, mem_done_o 1 cycle, stall high until DONE.
- Store half, addr 0x2002, d = 0x0000BEEF, gnt delayed 3 cycles:
  - req is held with be 1100, wdata 0xBEEFBEEF;
  - done arrives 5 cycles after start.
- Load word, addr 0x3001:
  - mem_misalign_o = 1, no req, stall 0;
  - width 11 at addr 0x3000 gives the same response.
- Load half, addr 0x4002, rdtype 1, flush asserted in WAIT:
  - rvalid is consumed;
  - mem_rdata_o is unchanged, no done pulse, return to IDLE.
- Two back-to-back stores:
  - exactly 1 idle cycle between the DONE of the first store and the req of the second;
  - reset asserted in REQ clears all outputs immediately.
